// File: rtl/hier_pkg.sv
// rtl/hier_pkg.sv - shared constants, index-width helper and child index type for the fan-in hierarchy
package hier_pkg;

  localparam int NUM_CHILD_DEF = 5;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(NUM_CHILD_DEF);

  typedef logic [IDX_W-1:0] child_idx_t;

endpackage

// File: rtl/hier_rr_arbiter.sv
// rtl/hier_rr_arbiter.sv - combinational round-robin arbiter; search starts just after ptr
module hier_rr_arbiter
  import hier_pkg::*;
#(
  parameter  int N  = NUM_CHILD_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          found
);

  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = IW'(c);
      end
    end
  end

endmodule

// File: rtl/hier_fanin_collector.sv
// rtl/hier_fanin_collector.sv - merges NUM_CHILD child streams into one registered, source-tagged upstream stream
module hier_fanin_collector
  import hier_pkg::*;
#(
  parameter  int NUM_CHILD = NUM_CHILD_DEF,
  parameter  int DATA_W    = 16,
  parameter  int CNT_W     = 16,
  localparam int SRC_W     = idx_w(NUM_CHILD)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        up_valid,
  output logic [DATA_W-1:0]           up_data,
  output logic [SRC_W-1:0]            up_src,
  input  logic                        up_ready,
  output logic [CNT_W-1:0]            beat_cnt
);

  logic                 up_valid_q, up_valid_d;
  logic [DATA_W-1:0]    up_data_q, up_data_d;
  logic [SRC_W-1:0]     up_src_q, up_src_d;
  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_CHILD-1:0] gnt;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 found, load_ok, child_hs, up_hs;

  hier_rr_arbiter #(.N(NUM_CHILD)) u_arb (
    .req     (child_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .found   (found)
  );

  always_comb begin
    load_ok    = !up_valid_q || up_ready;
    child_hs   = load_ok && found;
    up_hs      = up_valid_q && up_ready;
    // Ready is masked in reset so no child believes a beat was taken.
    child_ready = (rst_n && child_hs) ? gnt : '0;
    up_valid_d = up_valid_q;
    up_data_d  = up_data_q;
    up_src_d   = up_src_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (child_hs) begin
      up_valid_d = 1'b1;
      up_data_d  = child_data[gnt_idx*DATA_W +: DATA_W];
      up_src_d   = gnt_idx;
      ptr_d      = gnt_idx;
    end else if (up_hs) begin
      up_valid_d = 1'b0;
    end
    if (up_hs) beat_cnt_d = beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_valid_q <= 1'b0;
      up_data_q  <= '0;
      up_src_q   <= '0;
      ptr_q      <= SRC_W'(NUM_CHILD - 1);
      beat_cnt_q <= '0;
    end else begin
      up_valid_q <= up_valid_d;
      up_data_q  <= up_data_d;
      up_src_q   <= up_src_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign up_valid = up_valid_q;
  assign up_data  = up_data_q;
  assign up_src   = up_src_q;
  assign beat_cnt = beat_cnt_q;

endmodule
